// File: rtl/sar_adc_emu_multi_if.sv
// SAR ADC emulator bus: run/config inputs from
// the controller, conversion results back to it.
interface sar_adc_emu_multi_if #(
  parameter int NCH = 8,
  parameter int DW  = 10
);
  localparam int CHW = $clog2(NCH);

  logic           ADC_START;
  logic [1:0]     ADC_MODE;
  logic [NCH-1:0] ADC_CH_EN;
  logic [1:0]     ADC_DIV_SEL;
  logic           ADC_CKOUT;
  logic [DW-1:0]  ADC_DOUT;
  logic [CHW-1:0] ADC_CH_OUT;
  logic           ADC_EOC;
  logic           ADC_BUSY;
  logic           ADC_ERR;

  modport master (
    output ADC_START,
    output ADC_MODE,
    output ADC_CH_EN,
    output ADC_DIV_SEL,
    input  ADC_CKOUT,
    input  ADC_DOUT,
    input  ADC_CH_OUT,
    input  ADC_EOC,
    input  ADC_BUSY,
    input  ADC_ERR
  );

  modport slave (
    input  ADC_START,
    input  ADC_MODE,
    input  ADC_CH_EN,
    input  ADC_DIV_SEL,
    output ADC_CKOUT,
    output ADC_DOUT,
    output ADC_CH_OUT,
    output ADC_EOC,
    output ADC_BUSY,
    output ADC_ERR
  );
endinterface

// File: rtl/sar_adc_emu_multi.sv
// Multi-channel SAR ADC emulator: SAMPLE/CONVERT
// sequencing, scan/continuous modes, counted results.
module sar_adc_emu_multi #(
  parameter int NCH      = 8,
  parameter int DW       = 10,
  parameter int DIV_BASE = 16
) (
  input logic                ADC_CLKIN,
  input logic                ADC_RESETB,
  sar_adc_emu_multi_if.slave bus
);
  localparam int CHW = $clog2(NCH);
  localparam int CW  = DW - CHW;
  localparam int PW  = $clog2(DIV_BASE * 8 + 1);
  localparam int BW  = $clog2(DW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_CONV,
    S_DONE,
    S_WAIT_LOW
  } state_t;

  state_t state;
  state_t state_nx;

  logic           start;
  logic [1:0]     mode;
  logic [NCH-1:0] ch_en;
  logic [1:0]     div_sel;

  logic [PW-1:0]  per;
  logic [PW-1:0]  p_sel;
  logic [PW-1:0]  cnt;
  logic           tick;
  logic           half;
  logic           run;
  logic           fin;
  logic           load;

  logic [BW-1:0]  bit_cnt;
  logic [CHW-1:0] ch;
  logic [CHW-1:0] ch_nx;
  logic [CHW-1:0] ch_low;
  logic [CHW-1:0] ch_scan;
  logic [CW-1:0]  cnt_ch [NCH];

  logic           ckout;
  logic [DW-1:0]  dout;
  logic [CHW-1:0] ch_out;
  logic           eoc;
  logic           err;

  assign start   = bus.ADC_START;
  assign mode    = bus.ADC_MODE;
  assign ch_en   = bus.ADC_CH_EN;
  assign div_sel = bus.ADC_DIV_SEL;

  // Next enabled channel strictly after cur,
  // wrapping around; returns cur if mask is empty.
  function automatic logic [CHW-1:0] pick_next(
    input logic [NCH-1:0] m,
    input logic [CHW-1:0] cur
  );
    logic [CHW-1:0] r;
    logic [NCH-1:0] sh;
    logic           hit;
    int             idx;
    r   = cur;
    hit = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(cur) + k) % NCH;
      sh  = m >> idx;
      if (!hit && sh[0]) begin
        r   = CHW'(idx);
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  // Searching after the top index lands on the
  // lowest set bit first.
  assign ch_low  = pick_next(ch_en, CHW'(NCH - 1));
  assign ch_scan = pick_next(ch_en, ch);

  assign p_sel = PW'(DIV_BASE) << div_sel;
  assign tick  = (cnt == per - PW'(1));
  assign half  = (cnt == (per >> 1) - PW'(1));
  assign run   = start &&
                 ((state == S_SAMPLE) ||
                  (state == S_CONV));
  assign fin   = start && (state == S_CONV) &&
                 tick && (bit_cnt == '0);

  // State register.
  always_ff @(posedge ADC_CLKIN) begin
    if (!ADC_RESETB) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, channel choice and reload strobe.
  always_comb begin
    state_nx = state;
    ch_nx    = ch;
    load     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && (ch_en != '0)) begin
          state_nx = S_SAMPLE;
          ch_nx    = ch_low;
          load     = 1'b1;
        end
      end
      S_SAMPLE: begin
        if (!start) begin
          state_nx = S_IDLE;
        end else if (tick) begin
          state_nx = S_CONV;
        end
      end
      S_CONV: begin
        if (!start) begin
          state_nx = S_IDLE;
        end else if (tick && (bit_cnt == '0)) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        if (!start) begin
          state_nx = S_IDLE;
        end else begin
          unique case (mode)
            2'b01: begin
              state_nx = S_SAMPLE;
              load     = 1'b1;
            end
            2'b10: begin
              if (ch_en != '0) begin
                state_nx = S_SAMPLE;
                ch_nx    = ch_scan;
                load     = 1'b1;
              end else begin
                state_nx = S_IDLE;
              end
            end
            default: begin
              state_nx = S_WAIT_LOW;
            end
          endcase
        end
      end
      S_WAIT_LOW: begin
        if (!start) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Freeze period and channel at each new sample.
  always_ff @(posedge ADC_CLKIN) begin
    if (!ADC_RESETB) begin
      per <= PW'(DIV_BASE);
      ch  <= '0;
    end else if (load) begin
      per <= p_sel;
      ch  <= ch_nx;
    end
  end

  // Clock divider, free-running only while busy.
  always_ff @(posedge ADC_CLKIN) begin
    if (!ADC_RESETB) begin
      cnt <= '0;
    end else if (load || !run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

  // Conversion clock: high for the second half
  // of each divider period.
  always_ff @(posedge ADC_CLKIN) begin
    if (!ADC_RESETB) begin
      ckout <= 1'b0;
    end else if (run && half) begin
      ckout <= 1'b1;
    end else if (run && !tick) begin
      ckout <= ckout;
    end else begin
      ckout <= 1'b0;
    end
  end

  // Bit counter: loaded leaving SAMPLE, one step
  // per divider tick in CONV.
  always_ff @(posedge ADC_CLKIN) begin
    if (!ADC_RESETB) begin
      bit_cnt <= '0;
    end else if (state == S_SAMPLE && tick) begin
      bit_cnt <= BW'(DW - 1);
    end else if (state == S_CONV && tick &&
                 bit_cnt != '0) begin
      bit_cnt <= bit_cnt - BW'(1);
    end
  end

  // Result capture; EOC is high for the DONE cycle.
  always_ff @(posedge ADC_CLKIN) begin
    if (!ADC_RESETB) begin
      eoc    <= 1'b0;
      dout   <= '0;
      ch_out <= '0;
    end else begin
      eoc <= fin;
      if (fin) begin
        dout   <= {ch, cnt_ch[ch]};
        ch_out <= ch;
      end
    end
  end

  // Per-channel conversion counts, bumped with
  // each completed result.
  always_ff @(posedge ADC_CLKIN) begin
    if (!ADC_RESETB) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_ch[i] <= '0;
      end
    end else if (fin) begin
      cnt_ch[ch] <= cnt_ch[ch] + CW'(1);
    end
  end

  // Error flag: run requested with nothing enabled.
  always_ff @(posedge ADC_CLKIN) begin
    if (!ADC_RESETB) begin
      err <= 1'b0;
    end else begin
      err <= (state == S_IDLE) && start &&
             (ch_en == '0);
    end
  end

  assign bus.ADC_CKOUT  = ckout;
  assign bus.ADC_DOUT   = dout;
  assign bus.ADC_CH_OUT = ch_out;
  assign bus.ADC_EOC    = eoc;
  assign bus.ADC_ERR    = err;
  assign bus.ADC_BUSY   = (state == S_SAMPLE) ||
                          (state == S_CONV) ||
                          (state == S_DONE);
endmodule

// File: tb/tb_sar_adc_emu_multi.sv
// Directed bench for the SAR ADC emulator
// (NCH=8, DW=10, DIV_BASE=16).
module tb_sar_adc_emu_multi;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  sar_adc_emu_multi_if #(.NCH(8), .DW(10)) bus ();

  sar_adc_emu_multi #(
    .NCH(8),
    .DW(10),
    .DIV_BASE(16)
  ) dut (
    .ADC_CLKIN(clk),
    .ADC_RESETB(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n = sample index (1 = edge that sees the
  // inputs) at which EOC is seen, -1 on timeout.
  task automatic wait_eoc(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (bus.ADC_EOC === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic go_idle();
    bus.ADC_START = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    logic [16:0] o;
    rst_n = 1'b0;
    bus.ADC_START = 1'b0;
    bus.ADC_MODE = 2'b00;
    bus.ADC_CH_EN = 8'h00;
    bus.ADC_DIV_SEL = 2'b00;
    repeat (3) step();
    o = {bus.ADC_CKOUT, bus.ADC_DOUT, bus.ADC_CH_OUT,
         bus.ADC_EOC, bus.ADC_BUSY, bus.ADC_ERR};
    n_cmp++;
    if (o !== 17'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", o);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    int n;
    bus.ADC_MODE = 2'b00;
    bus.ADC_CH_EN = 8'h04;
    bus.ADC_DIV_SEL = 2'b00;
    bus.ADC_START = 1'b1;
    wait_eoc(400, n);
    n_cmp++;
    if (n !== 177) begin
      n_bad++;
      $display("FAIL single_latency: got %0d want 177", n);
    end
    n_cmp++;
    if (bus.ADC_DOUT !== 10'h100) begin
      n_bad++;
      $display("FAIL single_dout: got %h want 100",
               bus.ADC_DOUT);
    end
    n_cmp++;
    if (bus.ADC_CH_OUT !== 3'd2) begin
      n_bad++;
      $display("FAIL single_ch: got %0d want 2",
               bus.ADC_CH_OUT);
    end
    step();
    n_cmp++;
    if ({bus.ADC_EOC, bus.ADC_BUSY} !== 2'b00) begin
      n_bad++;
      $display("FAIL single_after: eoc/busy got %b want 00",
               {bus.ADC_EOC, bus.ADC_BUSY});
    end
    wait_eoc(400, n);
    n_cmp++;
    if (n !== -1) begin
      n_bad++;
      $display("FAIL single_no_rerun: eoc at %0d want none", n);
    end
    bus.ADC_START = 1'b0;
    repeat (2) step();
    bus.ADC_START = 1'b1;
    wait_eoc(400, n);
    n_cmp++;
    if (n !== 177 || bus.ADC_DOUT !== 10'h101) begin
      n_bad++;
      $display("FAIL single_rerun: n %0d dout %h want 177 101",
               n, bus.ADC_DOUT);
    end
    go_idle();
  endtask

  task automatic test_ckout();
    int n;
    int pulses;
    int runlen;
    int hi_bad;
    int lo_bad;
    logic prev;
    bus.ADC_MODE = 2'b00;
    bus.ADC_CH_EN = 8'h02;
    bus.ADC_DIV_SEL = 2'd2;
    bus.ADC_START = 1'b1;
    n = -1;
    pulses = 0;
    runlen = 0;
    hi_bad = 0;
    lo_bad = 0;
    prev = 1'b0;
    for (int i = 1; i <= 1000; i++) begin
      step();
      if (bus.ADC_CKOUT === prev) begin
        runlen++;
      end else begin
        if (prev === 1'b1 && runlen != 32) hi_bad++;
        if (prev === 1'b0 && pulses > 0 && runlen != 32)
          lo_bad++;
        if (prev === 1'b0) pulses++;
        runlen = 1;
        prev = bus.ADC_CKOUT;
      end
      if (bus.ADC_EOC === 1'b1) begin
        n = i;
        break;
      end
    end
    n_cmp++;
    if (n !== 705) begin
      n_bad++;
      $display("FAIL ck_latency: got %0d want 705", n);
    end
    n_cmp++;
    if (pulses !== 11) begin
      n_bad++;
      $display("FAIL ck_pulses: got %0d want 11", pulses);
    end
    n_cmp++;
    if (hi_bad !== 0 || lo_bad !== 0) begin
      n_bad++;
      $display("FAIL ck_duty: bad hi %0d lo %0d want 0 0",
               hi_bad, lo_bad);
    end
    n_cmp++;
    if (bus.ADC_DOUT !== 10'h080 || bus.ADC_CH_OUT !== 3'd1)
    begin
      n_bad++;
      $display("FAIL ck_dout: got %h ch %0d want 080 ch 1",
               bus.ADC_DOUT, bus.ADC_CH_OUT);
    end
    go_idle();
  endtask

  task automatic test_scan();
    int n;
    logic [9:0] exp_d [4];
    logic [2:0] exp_c [4];
    exp_d[0] = 10'h000; exp_c[0] = 3'd0;
    exp_d[1] = 10'h180; exp_c[1] = 3'd3;
    exp_d[2] = 10'h380; exp_c[2] = 3'd7;
    exp_d[3] = 10'h001; exp_c[3] = 3'd0;
    bus.ADC_MODE = 2'b10;
    bus.ADC_CH_EN = 8'h89;
    bus.ADC_DIV_SEL = 2'd0;
    bus.ADC_START = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_eoc(400, n);
      n_cmp++;
      if (n !== 177 || bus.ADC_DOUT !== exp_d[k] ||
          bus.ADC_CH_OUT !== exp_c[k]) begin
        n_bad++;
        $display("FAIL scan_%0d: n %0d dout %h ch %0d want 177 %h %0d",
                 k, n, bus.ADC_DOUT, bus.ADC_CH_OUT,
                 exp_d[k], exp_c[k]);
      end
    end
    go_idle();
  endtask

  task automatic test_continuous();
    int n;
    int seq_bad;
    int gap_bad;
    logic [9:0] exp_d;
    bus.ADC_MODE = 2'b01;
    bus.ADC_CH_EN = 8'h20;
    bus.ADC_DIV_SEL = 2'd0;
    bus.ADC_START = 1'b1;
    seq_bad = 0;
    gap_bad = 0;
    for (int k = 1; k <= 130; k++) begin
      wait_eoc(400, n);
      exp_d = 10'(5 * 128 + (k - 1) % 128);
      if (bus.ADC_DOUT !== exp_d) seq_bad++;
      if (n !== 177) gap_bad++;
      if (k == 128) begin
        n_cmp++;
        if (bus.ADC_DOUT !== 10'h2FF) begin
          n_bad++;
          $display("FAIL cont_128: got %h want 2ff",
                   bus.ADC_DOUT);
        end
      end
      if (k == 129) begin
        n_cmp++;
        if (bus.ADC_DOUT !== 10'h280) begin
          n_bad++;
          $display("FAIL cont_129: got %h want 280",
                   bus.ADC_DOUT);
        end
      end
    end
    n_cmp++;
    if (seq_bad !== 0 || gap_bad !== 0) begin
      n_bad++;
      $display("FAIL cont_seq: bad dout %0d bad gap %0d want 0 0",
               seq_bad, gap_bad);
    end
    go_idle();
  endtask

  task automatic test_abort();
    int n;
    bus.ADC_MODE = 2'b00;
    bus.ADC_CH_EN = 8'h40;
    bus.ADC_DIV_SEL = 2'd0;
    bus.ADC_START = 1'b1;
    wait_eoc(400, n);
    n_cmp++;
    if (bus.ADC_DOUT !== 10'h300) begin
      n_bad++;
      $display("FAIL abort_first: got %h want 300",
               bus.ADC_DOUT);
    end
    bus.ADC_START = 1'b0;
    repeat (2) step();
    bus.ADC_START = 1'b1;
    repeat (110) step();
    n_cmp++;
    if (bus.ADC_CKOUT !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_ck_pre: got %b want 1",
               bus.ADC_CKOUT);
    end
    bus.ADC_START = 1'b0;
    step();
    n_cmp++;
    if ({bus.ADC_CKOUT, bus.ADC_BUSY, bus.ADC_EOC} !== 3'b000)
    begin
      n_bad++;
      $display("FAIL abort_next: ck/busy/eoc got %b want 000",
               {bus.ADC_CKOUT, bus.ADC_BUSY, bus.ADC_EOC});
    end
    wait_eoc(300, n);
    n_cmp++;
    if (n !== -1 || bus.ADC_DOUT !== 10'h300 ||
        bus.ADC_CH_OUT !== 3'd6) begin
      n_bad++;
      $display("FAIL abort_hold: n %0d dout %h ch %0d want -1 300 6",
               n, bus.ADC_DOUT, bus.ADC_CH_OUT);
    end
    bus.ADC_START = 1'b1;
    wait_eoc(400, n);
    n_cmp++;
    if (n !== 177 || bus.ADC_DOUT !== 10'h301) begin
      n_bad++;
      $display("FAIL abort_restart: n %0d dout %h want 177 301",
               n, bus.ADC_DOUT);
    end
    go_idle();
  endtask

  task automatic test_err_reset();
    int n;
    logic [16:0] o;
    bus.ADC_MODE = 2'b00;
    bus.ADC_CH_EN = 8'h00;
    bus.ADC_START = 1'b1;
    repeat (2) step();
    n_cmp++;
    if ({bus.ADC_ERR, bus.ADC_BUSY} !== 2'b10) begin
      n_bad++;
      $display("FAIL err_set: err/busy got %b want 10",
               {bus.ADC_ERR, bus.ADC_BUSY});
    end
    bus.ADC_START = 1'b0;
    step();
    n_cmp++;
    if (bus.ADC_ERR !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clear: got %b want 0", bus.ADC_ERR);
    end
    bus.ADC_CH_EN = 8'h04;
    bus.ADC_START = 1'b1;
    repeat (50) step();
    n_cmp++;
    if (bus.ADC_BUSY !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre_busy: got %b want 1", bus.ADC_BUSY);
    end
    rst_n = 1'b0;
    step();
    o = {bus.ADC_CKOUT, bus.ADC_DOUT, bus.ADC_CH_OUT,
         bus.ADC_EOC, bus.ADC_BUSY, bus.ADC_ERR};
    n_cmp++;
    if (o !== 17'h0) begin
      n_bad++;
      $display("FAIL rst_mid_conv: got %h want 0", o);
    end
    rst_n = 1'b1;
    wait_eoc(400, n);
    n_cmp++;
    if (n !== 177 || bus.ADC_DOUT !== 10'h100) begin
      n_bad++;
      $display("FAIL rst_count_clear: n %0d dout %h want 177 100",
               n, bus.ADC_DOUT);
    end
    go_idle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_ckout();
    test_scan();
    test_continuous();
    test_abort();
    test_err_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
